// File: rtl/wb_burst_traffic_gen.sv
// wb_burst_traffic_gen
// Self-checking Wishbone B3 burst master. A run writes an address-derived
// pattern to a memory window in incrementing linear bursts, then reads the
// window back and counts every beat whose data differs from the pattern.
//
// Ports:
//   wb_clk   in   clock
//   wb_rst   in   synchronous active-high reset
//   start    in   one-cycle pulse launching a run (ignored while busy)
//   adr_o    out  [31:0] Wishbone address
//   dat_o    out  [31:0] write data (always the pattern for adr_o)
//   sel_o    out  [3:0]  byte selects, fixed 4'hf
//   cti_o    out  [2:0]  cycle type: 010 incrementing, 111 last beat
//   bte_o    out  [1:0]  burst type extension, fixed linear
//   we_o     out  write enable
//   cyc_o    out  bus cycle
//   stb_o    out  strobe
//   dat_i    in   [31:0] read data
//   ack_i    in   acknowledge
//   busy     out  run in progress
//   done     out  run finished, held until the next start
//   ok       out  valid with done: no read errors and no watchdog abort
//   timeout  out  sticky watchdog abort flag
//   err_cnt  out  [15:0] saturating count of read mismatches
module wb_burst_traffic_gen #(
   parameter logic [31:0] ADR_BASE     = 32'h0000_0000,
   parameter int          BURST_LEN    = 4,
   parameter int          NR_OF_BURSTS = 16,
   parameter logic [31:0] SEED         = 32'hA5A5_5A5A,
   parameter int          TIMEOUT      = 1024
) (
   input  logic        wb_clk,
   input  logic        wb_rst,
   input  logic        start,
   output logic [31:0] adr_o,
   output logic [31:0] dat_o,
   output logic [3:0]  sel_o,
   output logic [2:0]  cti_o,
   output logic [1:0]  bte_o,
   output logic        we_o,
   output logic        cyc_o,
   output logic        stb_o,
   input  logic [31:0] dat_i,
   input  logic        ack_i,
   output logic        busy,
   output logic        done,
   output logic        ok,
   output logic        timeout,
   output logic [15:0] err_cnt
);

   typedef enum logic [2:0] {IDLE, WR, WGAP, RD, RGAP, FIN} state_t;

   localparam logic [4:0]  LAST_BEAT  = 5'(BURST_LEN - 1);
   localparam logic [12:0] LAST_BURST = 13'(NR_OF_BURSTS - 1);
   localparam logic [31:0] LAST_WAIT  = 32'(TIMEOUT - 1);
   localparam logic [2:0]  CTI_INCR   = 3'b010;
   localparam logic [2:0]  CTI_END    = 3'b111;

   state_t      state;
   logic [4:0]  beat;
   logic [12:0] burst;
   logic [31:0] wait_cnt;

   logic        accept;
   logic [31:0] adr_next;
   logic [4:0]  beat_next;

   // Reference pattern; the two low address bits never reach the data.
   function automatic logic [31:0] pattern(input logic [31:0] a);
      return (a & 32'hFFFF_FFFC) ^ SEED;
   endfunction

   assign sel_o     = 4'hf;
   assign bte_o     = 2'b00;
   assign accept    = stb_o & ack_i;
   assign adr_next  = adr_o + 32'd4;
   assign beat_next = beat + 5'd1;

   // Whole controller: state, bus outputs, counters and status flags all
   // live in one registered block so every output comes straight off a flop.
   // dat_o always tracks pattern(adr_o), so it serves both as write data and
   // as the reference for the read compare.
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state    <= IDLE;
         adr_o    <= ADR_BASE;
         dat_o    <= pattern(ADR_BASE);
         cti_o    <= 3'b000;
         we_o     <= 1'b0;
         cyc_o    <= 1'b0;
         stb_o    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         ok       <= 1'b0;
         timeout  <= 1'b0;
         err_cnt  <= 16'd0;
         beat     <= 5'd0;
         burst    <= 13'd0;
         wait_cnt <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= WR;
                  adr_o    <= ADR_BASE;
                  dat_o    <= pattern(ADR_BASE);
                  cti_o    <= (LAST_BEAT == 5'd0) ? CTI_END : CTI_INCR;
                  we_o     <= 1'b1;
                  cyc_o    <= 1'b1;
                  stb_o    <= 1'b1;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  ok       <= 1'b0;
                  timeout  <= 1'b0;
                  err_cnt  <= 16'd0;
                  beat     <= 5'd0;
                  burst    <= 13'd0;
                  wait_cnt <= 32'd0;
               end
            end

            // Both data phases share the beat handling; stb_o is always high
            // here, so a missing ack is a wait state for the watchdog.
            WR, RD: begin
               if (accept) begin
                  wait_cnt <= 32'd0;
                  adr_o    <= adr_next;
                  dat_o    <= pattern(adr_next);
                  if (state == RD && dat_i != pattern(adr_o) && err_cnt != 16'hffff)
                     err_cnt <= err_cnt + 16'd1;
                  if (beat == LAST_BEAT) begin
                     beat  <= 5'd0;
                     cyc_o <= 1'b0;
                     stb_o <= 1'b0;
                     cti_o <= 3'b000;
                     if (state == WR)
                        state <= WGAP;
                     else
                        state <= RGAP;
                  end else begin
                     beat  <= beat_next;
                     cti_o <= (beat_next == LAST_BEAT) ? CTI_END : CTI_INCR;
                  end
               end else if (wait_cnt == LAST_WAIT) begin
                  timeout <= 1'b1;
                  cyc_o   <= 1'b0;
                  stb_o   <= 1'b0;
                  cti_o   <= 3'b000;
                  state   <= FIN;
               end else begin
                  wait_cnt <= wait_cnt + 32'd1;
               end
            end

            // After the last write burst the address restarts at the base
            // for the read-back phase.
            WGAP: begin
               cyc_o    <= 1'b1;
               stb_o    <= 1'b1;
               cti_o    <= (LAST_BEAT == 5'd0) ? CTI_END : CTI_INCR;
               wait_cnt <= 32'd0;
               if (burst == LAST_BURST) begin
                  burst <= 13'd0;
                  we_o  <= 1'b0;
                  adr_o <= ADR_BASE;
                  dat_o <= pattern(ADR_BASE);
                  state <= RD;
               end else begin
                  burst <= burst + 13'd1;
                  state <= WR;
               end
            end

            RGAP: begin
               if (burst == LAST_BURST) begin
                  burst <= 13'd0;
                  state <= FIN;
               end else begin
                  burst    <= burst + 13'd1;
                  cyc_o    <= 1'b1;
                  stb_o    <= 1'b1;
                  cti_o    <= (LAST_BEAT == 5'd0) ? CTI_END : CTI_INCR;
                  wait_cnt <= 32'd0;
                  state    <= RD;
               end
            end

            // FIN does not look at start, so a pulse landing here is dropped.
            FIN: begin
               we_o  <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b1;
               ok    <= (err_cnt == 16'd0) && !timeout;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_burst_traffic_gen.sv
// tb_wb_burst_traffic_gen
// Drives two generator instances: instance A (base 0x100, 2 bursts of 4,
// watchdog 16) against a configurable slave model, instance B (base
// 0xFFFF_FFF8, 1 burst of 4) against an ideal slave for address wrap.
module tb_wb_burst_traffic_gen;

   localparam logic [31:0] SEED   = 32'hA5A5_5A5A;
   localparam logic [31:0] BASE_A = 32'h0000_0100;
   localparam logic [31:0] BASE_B = 32'hFFFF_FFF8;

   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [2:0]  cti;
   } beat_t;

   typedef struct {
      string       name;
      int          mode;
      logic        ok;
      logic        to;
      logic [15:0] err;
      int          beats;
      int          span;
      int          drop;
   } run_t;

   logic        wb_clk = 1'b0;
   logic        wb_rst;

   logic        start_a, we_a, cyc_a, stb_a, ack_a, busy_a, done_a, ok_a, timeout_a;
   logic [31:0] adr_a, dat_o_a, dat_i_a;
   logic [3:0]  sel_a;
   logic [2:0]  cti_a;
   logic [1:0]  bte_a;
   logic [15:0] err_a;

   logic        start_b, we_b, cyc_b, stb_b, ack_b, busy_b, done_b, ok_b, timeout_b;
   logic [31:0] adr_b, dat_o_b, dat_i_b;
   logic [3:0]  sel_b;
   logic [2:0]  cti_b;
   logic [1:0]  bte_b;
   logic [15:0] err_b;

   int          vectors = 0;
   int          miscompares = 0;

   int          mode_a = 0;
   int          ws_cnt = 0;
   logic        ack_gate;
   logic [31:0] mem_a [8];
   logic [31:0] mem_b [4];

   beat_t       log_a[$];
   beat_t       log_b[$];
   beat_t       exp_a [16];
   beat_t       exp_b [8];
   run_t        runs [4];

   int          cycle_n = 0;
   int          first_a = -1, done_at_a = -1, stall_a = -1, drop_a = -1;
   int          first_b = -1, done_at_b = -1;
   logic        pend_a = 1'b0;
   logic [66:0] held_a = '0;

   always #5 wb_clk = ~wb_clk;

   wb_burst_traffic_gen #(
      .ADR_BASE(BASE_A), .BURST_LEN(4), .NR_OF_BURSTS(2), .SEED(SEED), .TIMEOUT(16)
   ) dut_a (
      .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start_a),
      .adr_o(adr_a), .dat_o(dat_o_a), .sel_o(sel_a), .cti_o(cti_a), .bte_o(bte_a),
      .we_o(we_a), .cyc_o(cyc_a), .stb_o(stb_a), .dat_i(dat_i_a), .ack_i(ack_a),
      .busy(busy_a), .done(done_a), .ok(ok_a), .timeout(timeout_a), .err_cnt(err_a)
   );

   wb_burst_traffic_gen #(
      .ADR_BASE(BASE_B), .BURST_LEN(4), .NR_OF_BURSTS(1), .SEED(SEED), .TIMEOUT(64)
   ) dut_b (
      .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start_b),
      .adr_o(adr_b), .dat_o(dat_o_b), .sel_o(sel_b), .cti_o(cti_b), .bte_o(bte_b),
      .we_o(we_b), .cyc_o(cyc_b), .stb_o(stb_b), .dat_i(dat_i_b), .ack_i(ack_b),
      .busy(busy_b), .done(done_b), .ok(ok_b), .timeout(timeout_b), .err_cnt(err_b)
   );

   function automatic logic [31:0] expPat(input logic [31:0] a);
      return {a[31:2], 2'b00} ^ SEED;
   endfunction

   // Slave A: mode 0 immediate ack, 1 ack every third cycle, 2 immediate ack
   // with bit 0 flipped on reads of 0x108/0x110, 3 never acks the write to 0x108.
   always_comb begin
      ack_gate = 1'b1;
      case (mode_a)
         1: ack_gate = (ws_cnt == 2);
         3: ack_gate = !(we_a && adr_a == 32'h108);
         default: ack_gate = 1'b1;
      endcase
      ack_a   = stb_a & ack_gate;
      dat_i_a = mem_a[adr_a[4:2]];
      if (mode_a == 2 && (adr_a == 32'h108 || adr_a == 32'h110))
         dat_i_a[0] = ~dat_i_a[0];
   end

   always_comb begin
      ack_b   = stb_b;
      dat_i_b = mem_b[adr_b[3:2]];
   end

   // Wait-state phase advances on the active edge so the gate is steady
   // around the sampling edge.
   always @(posedge wb_clk) begin
      ws_cnt <= (ws_cnt == 2) ? 0 : ws_cnt + 1;
   end

   task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Bus monitor: logs accepted beats, fills the slave memories, checks that
   // a stalled beat holds address/data/cti, and records cycle timestamps.
   always @(negedge wb_clk) begin
      cycle_n++;
      if (cyc_a && first_a < 0) first_a = cycle_n;
      if (done_a && first_a >= 0 && done_at_a < 0) done_at_a = cycle_n;
      if (mode_a == 3 && stb_a && we_a && adr_a == 32'h108 && stall_a < 0) stall_a = cycle_n;
      if (stall_a >= 0 && !cyc_a && drop_a < 0) drop_a = cycle_n;
      if (pend_a && stb_a)
         checkOutput("hold_a", 72'({adr_a, dat_o_a, cti_a}), 72'(held_a));
      pend_a = stb_a && !ack_a;
      held_a = {adr_a, dat_o_a, cti_a};
      if (stb_a && ack_a) begin
         log_a.push_back(beat_t'{we_a, adr_a, dat_o_a, cti_a});
         if (we_a) mem_a[adr_a[4:2]] = dat_o_a;
      end
      if (cyc_b && first_b < 0) first_b = cycle_n;
      if (done_b && first_b >= 0 && done_at_b < 0) done_at_b = cycle_n;
      if (stb_b && ack_b) begin
         log_b.push_back(beat_t'{we_b, adr_b, dat_o_b, cti_b});
         if (we_b) mem_b[adr_b[3:2]] = dat_o_b;
      end
   end

   task automatic applyStimulus(input int mode);
      mode_a    = mode;
      log_a.delete();
      first_a   = -1;
      done_at_a = -1;
      stall_a   = -1;
      drop_a    = -1;
      @(posedge wb_clk); #1 start_a = 1'b1;
      @(posedge wb_clk); #1 start_a = 1'b0;
      for (int c = 0; c < 3000 && !done_a; c++) begin
         @(posedge wb_clk); #1;
      end
      @(negedge wb_clk); #1;
   endtask

   task automatic checkRun(input run_t r);
      beat_t act, ex;
      checkOutput({r.name, " done"}, 72'(done_a), 72'(1));
      checkOutput({r.name, " busy"}, 72'(busy_a), 72'(0));
      checkOutput({r.name, " ok"}, 72'(ok_a), 72'(r.ok));
      checkOutput({r.name, " timeout"}, 72'(timeout_a), 72'(r.to));
      checkOutput({r.name, " err_cnt"}, 72'(err_a), 72'(r.err));
      checkOutput({r.name, " beat count"}, 72'(log_a.size()), 72'(r.beats));
      for (int i = 0; i < r.beats; i++) begin
         act = (i < log_a.size()) ? log_a[i] : '0;
         ex  = exp_a[i];
         if (!ex.we) begin
            act.dat = '0;
            ex.dat  = '0;
         end
         checkOutput($sformatf("%s beat%0d", r.name, i), 72'(act), 72'(ex));
      end
      if (r.span >= 0)
         checkOutput({r.name, " cyc-to-done"}, 72'(done_at_a - first_a), 72'(r.span));
      if (r.drop >= 0)
         checkOutput({r.name, " stall-to-drop"}, 72'(drop_a - stall_a), 72'(r.drop));
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, " cyc"}, 72'(cyc_a), 72'(0));
      checkOutput({tag, " stb"}, 72'(stb_a), 72'(0));
      checkOutput({tag, " we"}, 72'(we_a), 72'(0));
      checkOutput({tag, " cti"}, 72'(cti_a), 72'(3'b000));
      checkOutput({tag, " bte"}, 72'(bte_a), 72'(2'b00));
      checkOutput({tag, " sel"}, 72'(sel_a), 72'(4'hf));
      checkOutput({tag, " adr"}, 72'(adr_a), 72'(32'h0000_0100));
      checkOutput({tag, " dat"}, 72'(dat_o_a), 72'(32'hA5A5_5B5A));
      checkOutput({tag, " status"}, 72'({busy_a, done_a, ok_a, timeout_a}), 72'(4'b0000));
      checkOutput({tag, " err_cnt"}, 72'(err_a), 72'(16'd0));
      checkOutput({tag, " adr_b"}, 72'(adr_b), 72'(32'hFFFF_FFF8));
   endtask

   initial begin
      logic [31:0] wrap_adr [4];
      int          c;

      wrap_adr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      for (int i = 0; i < 16; i++) begin
         exp_a[i].we  = (i < 8);
         exp_a[i].adr = BASE_A + 32'(4 * (i % 8));
         exp_a[i].dat = expPat(exp_a[i].adr);
         exp_a[i].cti = (i % 4 == 3) ? 3'b111 : 3'b010;
      end
      for (int i = 0; i < 8; i++) begin
         exp_b[i].we  = (i < 4);
         exp_b[i].adr = wrap_adr[i % 4];
         exp_b[i].dat = expPat(wrap_adr[i % 4]);
         exp_b[i].cti = (i % 4 == 3) ? 3'b111 : 3'b010;
      end
      runs[0] = '{"ideal",   0, 1'b1, 1'b0, 16'd0, 16, 21, -1};
      runs[1] = '{"waits",   1, 1'b1, 1'b0, 16'd0, 16, -1, -1};
      runs[2] = '{"corrupt", 2, 1'b0, 1'b0, 16'd2, 16, 21, -1};
      runs[3] = '{"timeout", 3, 1'b0, 1'b1, 16'd0,  2, -1, 16};
      for (int i = 0; i < 8; i++) mem_a[i] = '0;
      for (int i = 0; i < 4; i++) mem_b[i] = '0;

      wb_rst  = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      repeat (3) @(posedge wb_clk);
      #1;
      checkReset("reset");
      wb_rst = 1'b0;

      for (int r = 0; r < 4; r++) begin
         applyStimulus(runs[r].mode);
         checkRun(runs[r]);
      end

      // Reset in the middle of the read phase, then a clean run.
      mode_a = 0;
      @(posedge wb_clk); #1 start_a = 1'b1;
      @(posedge wb_clk); #1 start_a = 1'b0;
      c = 0;
      while (!(cyc_a && !we_a) && c < 200) begin
         @(posedge wb_clk); #1;
         c++;
      end
      checkOutput("midrst reached read phase", 72'({cyc_a, we_a}), 72'(2'b10));
      @(posedge wb_clk); #1 wb_rst = 1'b1;
      @(posedge wb_clk); #1;
      checkReset("midrst");
      wb_rst = 1'b0;
      runs[0].name = "after_reset";
      applyStimulus(0);
      checkRun(runs[0]);
      checkOutput("dat@0x104", 72'(log_a[1].dat), 72'(32'hA5A5_5B5E));

      // Address wrap on instance B, with a second start pulse while busy.
      log_b.delete();
      first_b   = -1;
      done_at_b = -1;
      @(posedge wb_clk); #1 start_b = 1'b1;
      @(posedge wb_clk); #1 start_b = 1'b0;
      repeat (2) @(posedge wb_clk);
      #1;
      checkOutput("wrap busy", 72'(busy_b), 72'(1));
      start_b = 1'b1;
      @(posedge wb_clk); #1 start_b = 1'b0;
      for (int k = 0; k < 500 && !done_b; k++) begin
         @(posedge wb_clk); #1;
      end
      @(negedge wb_clk); #1;
      checkOutput("wrap done", 72'(done_b), 72'(1));
      checkOutput("wrap ok", 72'(ok_b), 72'(1));
      checkOutput("wrap err_cnt", 72'(err_b), 72'(0));
      checkOutput("wrap beat count", 72'(log_b.size()), 72'(8));
      checkOutput("wrap cyc-to-done", 72'(done_at_b - first_b), 72'(11));
      for (int i = 0; i < 8; i++) begin
         beat_t act, ex;
         act = (i < log_b.size()) ? log_b[i] : '0;
         ex  = exp_b[i];
         if (!ex.we) begin
            act.dat = '0;
            ex.dat  = '0;
         end
         checkOutput($sformatf("wrap beat%0d", i), 72'(act), 72'(ex));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
